// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM-to-stream reader.
// FSM encoding, legal read latencies and buffer slack.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int RD_LAT_COMB = 1;
  localparam int RD_LAT_REG  = 2;
  localparam int FIFO_SLACK  = 2;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Small synchronous FIFO buffering RAM read data for the stream side.
// Depth need not be a power of two; pointers wrap explicitly.
module ram_stream_reader_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & (cnt_q != '0) & ~flush_i;
    wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? bump(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads len words from a RAM starting at base and streams them out.
// Define RAM_STREAM_READER_ABORT_EN to add the abort_i input.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_o,
  output logic                  output_reg_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  output logic                  tlast_o,
`ifdef RAM_STREAM_READER_ABORT_EN
  input  logic                  abort_i,
`endif
  input  logic                  tready_i
);

  localparam int DEPTH = RD_LATENCY + FIFO_SLACK;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LW    = ADDR_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LW-1:0]           len_q, len_d;
  logic [LW-1:0]           issue_cnt_q, issue_cnt_d;
  logic [LW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_pend_q, done_pend_d;
  logic [RD_LATENCY-1:0]   pipe_q, pipe_d;

  logic [CW-1:0]           fifo_cnt, infl_cnt;
  logic [CW:0]             occ;
  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    fifo_empty;
  logic                    credit_ok, issue;
  logic                    fire, last_beat, last_fire;
  logic                    kill;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign kill = abort_i & (state_q != IDLE);
`else
  assign kill = 1'b0;
`endif

  // Every issued read owns a FIFO slot until its beat leaves.
  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      infl_cnt = infl_cnt + CW'(pipe_q[i]);
    end
  end

  assign occ       = {1'b0, fifo_cnt} + {1'b0, infl_cnt};
  assign credit_ok = occ < (CW + 1)'(DEPTH);
  assign issue     = (state_q == ISSUE) & credit_ok & ~kill;

  assign tvalid_o  = ~fifo_empty & ~kill;
  assign fire      = tvalid_o & tready_i;
  assign last_beat = (beat_cnt_q == (len_q - 1'b1));
  assign tlast_o   = tvalid_o & last_beat;
  assign tdata_o   = tvalid_o ? fifo_rdata : '0;
  assign last_fire = fire & last_beat & (state_q == DRAIN);

  assign done_o    = done_pend_q | last_fire;
  assign busy_o    = busy_q;
  assign rd_o      = issue;
  assign rd_addr_o = addr_q;

  assign output_reg_en_o = (RD_LATENCY == RD_LAT_REG) ? 1'b1 : 1'b0;

  always_comb begin
    pipe_d[0] = issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (kill) pipe_d = '0;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    busy_d      = busy_q;
    done_pend_d = 1'b0;
    if (fire) beat_cnt_d = beat_cnt_q + 1'b1;
    if (done_o) busy_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          len_d       = len_i;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          busy_d      = 1'b1;
          if (len_i == '0) done_pend_d = 1'b1;
          else             state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == (len_q - 1'b1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d     = IDLE;
      done_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_pend_q <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= busy_d;
      done_pend_q <= done_pend_d;
      pipe_q      <= pipe_d;
    end
  end

  ram_stream_reader_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (kill),
    .push_i  (pipe_q[RD_LATENCY-1]),
    .wdata_i (rd_data_i),
    .pop_i   (fire),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized directed bench for ram_stream_reader (8-bit data, 5-bit addr,
// registered RAM with mem[a]=a), checked against a queue-based model.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] base = '0;
  logic [5:0] len = '0;
  logic       busy, done, rd_o, oreg;
  logic [4:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] ram_s1 = '0;
  logic [7:0] tdata;
  logic       tvalid, tlast;
  logic       tready = 1'b0;
`ifdef RAM_STREAM_READER_ABORT_EN
  logic       abort = 1'b0;
`endif

  ram_stream_reader dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .base_addr_i     (base),
    .len_i           (len),
    .busy_o          (busy),
    .done_o          (done),
    .rd_addr_o       (rd_addr),
    .rd_o            (rd_o),
    .output_reg_en_o (oreg),
    .rd_data_i       (rd_data),
    .tdata_o         (tdata),
    .tvalid_o        (tvalid),
    .tlast_o         (tlast),
`ifdef RAM_STREAM_READER_ABORT_EN
    .abort_i         (abort),
`endif
    .tready_i        (tready)
  );

  always #5 clk = ~clk;

  // Two-stage RAM read path holding mem[a] = a
  always @(posedge clk) begin
    ram_s1  <= 8'(rd_addr);
    rd_data <= ram_s1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [8:0] beats[$];
  time        beat_t[$];
  int         issued, popped, done_cnt, tv_cnt, cur_base;
  time        done_t, t_s;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_val;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        chk("hold_valid", 32'(tvalid), 1);
        chk("hold_data", 32'({tlast, tdata}), 32'(hold_val));
      end
      hold_pend = tvalid & ~tready;
      hold_val  = {tlast, tdata};
      if (rd_o) begin
        chk("credit", 32'((issued - popped) < 4), 1);
        chk("rd_addr", 32'(rd_addr), (cur_base + issued) % 32);
        issued++;
      end
      if (tvalid) tv_cnt++;
      if (tvalid && tready) begin
        beats.push_back({tlast, tdata});
        beat_t.push_back($time);
        popped++;
      end
      if (done) begin
        done_cnt++;
        done_t = $time;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  function automatic logic rnd(input int pct);
    return (int'($urandom_range(99)) < pct);
  endfunction

  task automatic clear_mon();
    beats.delete();
    beat_t.delete();
    issued    = 0;
    popped    = 0;
    done_cnt  = 0;
    tv_cnt    = 0;
    hold_pend = 1'b0;
  endtask

  task automatic chk_rst_outs();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_oreg", 32'(oreg), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_rst_outs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic run(input int b, input int l, input int pct,
                     input int rst_at);
    int  n;
    bit  ok;
    clear_mon();
    cur_base = b;
    @(posedge clk);
    #1;
    start  = 1'b1;
    base   = 5'(b);
    len    = 6'(l);
    tready = rnd(pct);
    @(posedge clk);
    t_s = $time;
    #1;
    start  = 1'b0;
    base   = 5'($urandom);
    len    = 6'($urandom);
    tready = rnd(pct);
    @(negedge clk);
    chk("busy_set", 32'(busy), 1);
    n  = 0;
    ok = 1'b0;
    while (n < 400) begin
      @(posedge clk);
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
      if (rst_at > 0 && beats.size() >= rst_at) begin
        #1;
        do_reset();
        return;
      end
      #1 tready = rnd(pct);
      n++;
    end
    chk("timeout", 32'(ok), 1);
    #1;
    @(negedge clk);
    chk("busy_clr", 32'(busy), 0);
    repeat (3) @(posedge clk);
    chk("beat_count", beats.size(), l);
    for (int k = 0; k < l && k < beats.size(); k++) begin
      chk("beat", 32'(beats[k]),
          32'({k == l - 1, 8'((b + k) % 32)}));
    end
    chk("done_once", done_cnt, 1);
    if (l == 0) begin
      chk("len0_done_t", 32'(done_t - t_s), 5);
      chk("len0_no_valid", tv_cnt, 0);
    end else if (beats.size() == l) begin
      chk("done_at_last", 32'(done_t), 32'(beat_t[l-1]));
      if (pct == 100) begin
        chk("first_lat", 32'((beat_t[0] - t_s - 5) / 10), 3);
        chk("b2b", 32'(beat_t[l-1] - beat_t[0]), (l - 1) * 10);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #12;
    chk_rst_outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();

    run(0, 8, 100, 0);
    run(30, 4, 100, 0);
    run(0, 32, 50, 0);
    run(7, 0, 100, 0);

    run(0, 16, 100, 3);
    repeat (6) @(posedge clk);
    chk("post_rst_quiet", tv_cnt, 0);
    run(5, 2, 100, 0);

    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(31)), int'($urandom_range(32, 1)),
          int'($urandom_range(100, 30)), 0);
    end

`ifdef RAM_STREAM_READER_ABORT_EN
    begin
      int n;
      clear_mon();
      cur_base = 0;
      @(posedge clk);
      #1;
      start  = 1'b1;
      base   = 5'd0;
      len    = 6'd10;
      tready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (n < 100 && beats.size() < 2) begin
        @(posedge clk);
        n++;
      end
      chk("abort_reach", 32'(beats.size()), 2);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_done", 32'(done), 1);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      repeat (8) @(posedge clk);
      chk("abort_beats", beats.size(), 2);
      chk("abort_done_once", done_cnt, 1);
      chk("abort_no_last", 32'(beats[1][8]), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
